rr_req_queue: RTL

- Upstream feeder for the 4-way round-robin arbiter. Holds one small FIFO of payloads per requester and drives the arbiter's req[3:0] from FIFO non-empty status.
- Consumes the arbiter's registered one-hot grant[3:0]. On each grant it pops the granted FIFO and presents that payload, tagged with its channel index, on a single shared output port one cycle later.

---
 rtl/rr_pkg.sv | 25 ++
 rtl/rr_req_fifo.sv | 84 ++++++++
 rtl/rr_req_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin request queue and arbiter.
// Contents:
//   NUM_CH / CH_IDX_W : channel count (fixed at 4) and channel index width
//   ch_vec_t          : one bit per channel
//   ch_idx_t          : channel index
//   onehot_lsb_idx    : index of the lowest set bit (0 when none is set)
package rr_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;

  typedef logic [NUM_CH-1:0]   ch_vec_t;
  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  function automatic ch_idx_t onehot_lsb_idx(input ch_vec_t vec);
    ch_idx_t idx;
    idx = '0;
    // Scan from the top so that the lowest set bit is written last and wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = ch_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_req_fifo.sv
// Single-channel synchronous FIFO used by rr_req_queue, one per requester.
// Parameters: DATA_W payload width, DEPTH entries (power of 2, >= 2).
// Ports:
//   clk, rst   clock, asynchronous active-high reset (pointers/count only)
//   push       write push_data at the tail (ignored when full)
//   push_data  DATA_W payload
//   pop        drop the head entry (ignored when empty)
//   head_data  current head entry (undefined content when empty)
//   count      number of stored entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module rr_req_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    count     = count_q;
    head_data = mem_q[rd_ptr_q];

    push_ok = push && !full;
    pop_ok  = pop && !empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      // Pointers are exactly log2(DEPTH) wide, so wrap is free.
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rr_req_queue.sv
// Upstream feeder for the 4-way round-robin arbiter. One FIFO per requester;
// req[] reflects FIFO non-empty status, and each grant pops the granted FIFO
// onto a shared output one cycle later, tagged with the channel index.
// Optional build macro: RR_REQ_QUEUE_GRANT_CNT_EN adds grant_cnt, one
// saturating 16-bit pop counter per channel.
// Parameters: DATA_W payload width, DEPTH entries per channel (power of 2, >= 2).
//   The channel count NUM_CH is fixed at 4 by rr_pkg.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    per-channel push request
//   in_data     per-channel payloads, channel i at [i*DATA_W +: DATA_W]
//   in_ready    per-channel space available (ignores same-cycle pops)
//   req         per-channel request to the arbiter (FIFO non-empty)
//   grant       registered one-hot grant from the arbiter
//   out_valid   one-cycle pulse per pop
//   out_data    popped payload (holds between pops)
//   out_ch      channel that supplied out_data (holds between pops)
//   err_grant   sticky: grant to an empty channel or non-one-hot grant
//   grant_cnt   (macro only) per-channel pop counters, channel i at [i*16 +: 16]
module rr_req_queue
  import rr_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        grant,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_IDX_W-1:0]      out_ch,
  output logic                     err_grant
`ifdef RR_REQ_QUEUE_GRANT_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]     grant_cnt
`endif
);

  ch_vec_t           fifo_full;
  ch_vec_t           fifo_empty;
  ch_vec_t           nonempty;
  ch_vec_t           push_vec;
  ch_vec_t           pop_vec;
  ch_vec_t           grant_ok;
  ch_idx_t           pop_idx;
  logic              pop_any;
  logic              multi_grant;
  logic [DATA_W-1:0] head_data [NUM_CH];
  logic [CNT_W-1:0]  ch_count  [NUM_CH];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  ch_idx_t           out_ch_q,    out_ch_d;
  logic              err_q,       err_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    rr_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_vec[g]),
      .push_data (in_data[g*DATA_W +: DATA_W]),
      .pop       (pop_vec[g]),
      .head_data (head_data[g]),
      .count     (ch_count[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      nonempty[i] = (ch_count[i] != '0);
    end

    // Both come straight from FIFO registers: no in_valid -> req path.
    in_ready = ~fifo_full;
    req      = ~fifo_empty;
    push_vec = in_valid & in_ready;

    // Only non-empty granted channels are candidates; lowest index wins
    // if the arbiter ever presents more than one.
    grant_ok    = grant & nonempty;
    pop_any     = |grant_ok;
    pop_idx     = onehot_lsb_idx(grant_ok);
    pop_vec     = pop_any ? (ch_vec_t'(1) << pop_idx) : '0;
    multi_grant = ((grant & (grant - ch_vec_t'(1))) != '0);

    err_d       = err_q | multi_grant | (|(grant & ~nonempty));
    out_valid_d = pop_any;
    out_data_d  = pop_any ? head_data[pop_idx] : out_data_q;
    out_ch_d    = pop_any ? pop_idx : out_ch_q;

    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_ch    = out_ch_q;
    err_grant = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      err_q       <= err_d;
    end
  end

`ifdef RR_REQ_QUEUE_GRANT_CNT_EN
  logic [15:0] gcnt_q [NUM_CH];
  logic [15:0] gcnt_d [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      gcnt_d[i] = gcnt_q[i];
      if (pop_vec[i] && (gcnt_q[i] != 16'hFFFF)) gcnt_d[i] = gcnt_q[i] + 16'd1;
      grant_cnt[i*16 +: 16] = gcnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) gcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) gcnt_q[i] <= gcnt_d[i];
    end
  end
`endif

endmodule
